// File: rtl/pwm_pkg.sv
// pwm_pkg: shared constants for the SPI-configured PWM output stage.
package pwm_pkg;
    localparam int NUM_CH = 16;
    localparam int CNT_W = 8;
    localparam logic [CNT_W-1:0] DUTY_FULL = 8'hFF;
    localparam logic [CNT_W-1:0] DUTY_ZERO = 8'h00;
    localparam int DEFAULT_CLK_DIV = 13;
endpackage

// File: rtl/pwm_timebase.sv
// pwm_timebase: free-running prescaled 8-bit PWM counter with period-start strobe.
module pwm_timebase
    import pwm_pkg::*;
#(
    parameter int CLK_DIV = DEFAULT_CLK_DIV
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [CNT_W-1:0] pwm_cnt,
    output logic             period_start
);
    localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);

    logic [15:0]      presc_q, presc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tick;

    always_comb begin
        tick         = presc_q == DIV_LAST;
        presc_d      = tick ? 16'd0 : presc_q + 16'd1;
        cnt_d        = tick ? cnt_q + CNT_W'(1) : cnt_q;
        period_start = tick && (cnt_q == {CNT_W{1'b1}});
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
            cnt_q   <= '0;
        end else begin
            presc_q <= presc_d;
            cnt_q   <= cnt_d;
        end
    end

    assign pwm_cnt = cnt_q;
endmodule

// File: rtl/pwm_peripheral.sv
// pwm_peripheral: 16 registered output pins, each off, static high or shared PWM.
module pwm_peripheral
    import pwm_pkg::*;
#(
    parameter int CLK_DIV = DEFAULT_CLK_DIV
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        en_reg_out_7_0,
    input  logic [7:0]        en_reg_out_15_8,
    input  logic [7:0]        en_reg_pwm_7_0,
    input  logic [7:0]        en_reg_pwm_15_8,
    input  logic [7:0]        pwm_duty_cycle,
    output logic [NUM_CH-1:0] out
);
    logic [NUM_CH-1:0] en_out, en_pwm, out_d, out_q;
    logic [CNT_W-1:0]  pwm_cnt, duty_sh_d, duty_sh_q;
    logic              period_start, pwm_sig;

    pwm_timebase #(.CLK_DIV(CLK_DIV)) u_timebase (
        .clk          (clk),
        .rst_n        (rst_n),
        .pwm_cnt      (pwm_cnt),
        .period_start (period_start)
    );

    // Duty is only sampled at the period boundary so a write never cuts a pulse short.
    always_comb begin
        en_out    = {en_reg_out_15_8, en_reg_out_7_0};
        en_pwm    = {en_reg_pwm_15_8, en_reg_pwm_7_0};
        duty_sh_d = period_start ? pwm_duty_cycle : duty_sh_q;
        pwm_sig   = (duty_sh_q == DUTY_FULL) || ((duty_sh_q != DUTY_ZERO) && (pwm_cnt < duty_sh_q));
        out_d     = en_out & (~en_pwm | {NUM_CH{pwm_sig}});
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            duty_sh_q <= DUTY_ZERO;
            out_q     <= '0;
        end else begin
            duty_sh_q <= duty_sh_d;
            out_q     <= out_d;
        end
    end

    assign out = out_q;
endmodule

// File: tb/tb_pwm_peripheral.sv
// tb_pwm_peripheral: directed checks of reset, duty sweep, shadowing, phase and static modes.
module tb_pwm_peripheral;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] en_out16, en_pwm16;
    logic [7:0]  duty, duty1, all_on;
    logic [15:0] out13, out1;
    int          n_vec = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    pwm_peripheral #(.CLK_DIV(13)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .en_reg_out_7_0  (en_out16[7:0]),
        .en_reg_out_15_8 (en_out16[15:8]),
        .en_reg_pwm_7_0  (en_pwm16[7:0]),
        .en_reg_pwm_15_8 (en_pwm16[15:8]),
        .pwm_duty_cycle  (duty),
        .out             (out13)
    );

    pwm_peripheral #(.CLK_DIV(1)) dut_div1 (
        .clk             (clk),
        .rst_n           (rst_n),
        .en_reg_out_7_0  (all_on),
        .en_reg_out_15_8 (all_on),
        .en_reg_pwm_7_0  (all_on),
        .en_reg_pwm_15_8 (all_on),
        .pwm_duty_cycle  (duty1),
        .out             (out1)
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic ch0(input bit s);
        return s ? out1[0] : out13[0];
    endfunction

    task automatic wait_rise(input bit s, input string tag);
        logic prev;
        int   t;
        t = 0;
        do begin
            prev = ch0(s);
            @(negedge clk);
            t++;
        end while (!(ch0(s) && !prev) && t < 10000);
        if (t >= 10000) chk({tag, " timeout"}, 0, 1);
    endtask

    task automatic count_high(input bit s, output int n);
        n = 0;
        while (ch0(s) && n < 10000) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic count_low(input bit s, output int n);
        n = 0;
        while (!ch0(s) && n < 10000) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic meas(input bit s, input string tag, output int hi, output int per);
        int lo;
        wait_rise(s, tag);
        count_high(s, hi);
        count_low(s, lo);
        per = hi + lo;
    endtask

    task automatic window_high(output int n);
        n = 0;
        repeat (3328) begin
            @(negedge clk);
            n += int'(out13[0]);
        end
    endtask

    initial begin
        int hi, per, lo, n, bad;
        rst_n    = 1'b0;
        en_out16 = '0;
        en_pwm16 = '0;
        duty     = 8'h00;
        duty1    = 8'h03;
        all_on   = 8'hFF;
        repeat (3) @(negedge clk);
        chk("reset out", out13, 0);
        rst_n    = 1'b1;
        duty     = 8'h80;
        en_out16 = 16'hFFFF;
        en_pwm16 = 16'hFFFF;
        wait_rise(0, "first rise");
        repeat (100) @(negedge clk);
        chk("pre-reset out", out13, 16'hFFFF);
        #2 rst_n = 1'b0;
        #1 chk("async reset out", out13, 0);
        repeat (3) @(negedge clk);
        chk("held reset out", out13, 0);
        rst_n = 1'b1;
        n = 0;
        while (n < 10000) begin
            @(negedge clk);
            if (out13[0]) break;
            n++;
        end
        chk("low period after reset", n, 3328);
        chk("all channels rise", out13, 16'hFFFF);
        count_high(0, hi);
        count_low(0, lo);
        chk("duty80 high", hi, 1664);
        chk("duty80 period", hi + lo, 3328);
        duty = 8'h01;
        meas(0, "duty01", hi, per);
        chk("duty01 high", hi, 13);
        chk("duty01 period", per, 3328);
        duty = 8'hFE;
        meas(0, "dutyFE", hi, per);
        chk("dutyFE high", hi, 3302);
        chk("dutyFE period", per, 3328);
        duty = 8'h00;
        repeat (3330) @(negedge clk);
        window_high(n);
        chk("duty00 high", n, 0);
        duty = 8'hFF;
        repeat (3330) @(negedge clk);
        window_high(n);
        chk("dutyFF high", n, 3328);
        duty = 8'h40;
        wait_rise(0, "glitch");
        count_high(0, hi);
        chk("glitch old high", hi, 832);
        repeat (1300 - hi) @(negedge clk);
        duty = 8'hC0;
        count_low(0, lo);
        chk("glitch period", 1300 + lo, 3328);
        count_high(0, hi);
        chk("glitch new high", hi, 2496);
        duty = 8'h20;
        wait_rise(0, "phase");
        bad = 0;
        n = 0;
        repeat (3328) begin
            if (out13 != 16'h0000 && out13 != 16'hFFFF) bad++;
            if (out13 == 16'hFFFF) n++;
            @(negedge clk);
        end
        chk("phase misaligned", bad, 0);
        chk("phase high", n, 416);
        en_out16 = 16'h00F0;
        en_pwm16 = 16'h0000;
        @(negedge clk);
        chk("static high", out13, 16'h00F0);
        en_pwm16 = 16'h00FF;
        bad = 0;
        n = 0;
        repeat (3328) begin
            @(negedge clk);
            if ((out13 & 16'hFF0F) != 0) bad++;
            if (out13 == 16'h00F0) n++;
        end
        chk("static leak", bad, 0);
        chk("static pwm high", n, 416);
        en_out16 = 16'h0000;
        @(negedge clk);
        chk("enable off", out13, 0);
        meas(1, "div1", hi, per);
        chk("div1 high", hi, 3);
        chk("div1 period", per, 256);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
